// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, issues one outstanding word
// read at a time and hands {instruction, p_count} downstream through a 2-entry buffer.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] p_count,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    // Handshakes: a beat moves when valid and ready are both high on a rising edge;
    // valid never waits on ready, and a raised valid (or imem_req) holds its payload
    // stable until the beat completes, except when a redirect or reset flushes it.

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] drain_addr;
    logic        outstanding;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        accept;
    logic        load_entry;
    logic        xfer;
    logic        start_drain;

    // A response only counts while a request is actually being presented.
    assign accept      = imem_req & imem_rvalid;
    assign load_entry  = accept & (state == RUN) & ~redirect_valid;
    assign xfer        = inst_valid & inst_ready;
    assign start_drain = redirect_valid & (state == RUN) & outstanding & ~imem_rvalid;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        if (state == RUN) begin
            imem_req  = rst_n & ~skid_valid;
            imem_addr = fetch_pc;
            if (start_drain) begin
                state_nxt = DRAIN;
            end
        end else begin
            // The memory has already committed to drain_addr, so keep asking for it.
            imem_req  = rst_n;
            imem_addr = drain_addr;
            if (accept) begin
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC & WORD_MASK;
            drain_addr  <= 32'h0;
            outstanding <= 1'b0;
            skid_valid  <= 1'b0;
            skid_instr  <= 32'h0;
            skid_pc     <= 32'h0;
            inst_valid  <= 1'b0;
            instruction <= 32'h0;
            p_count     <= 32'h0;
        end else begin
            state       <= state_nxt;
            outstanding <= imem_req & ~imem_rvalid;

            if (redirect_valid) begin
                fetch_pc   <= redirect_pc & WORD_MASK;
                inst_valid <= 1'b0;
                skid_valid <= 1'b0;
                if (start_drain) begin
                    drain_addr <= imem_addr;
                end
            end else begin
                if (load_entry) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end

                if (xfer || !inst_valid) begin
                    // Output register is free this cycle: oldest data first.
                    if (skid_valid) begin
                        instruction <= skid_instr;
                        p_count     <= skid_pc;
                        inst_valid  <= 1'b1;
                        skid_valid  <= 1'b0;
                    end else if (load_entry) begin
                        instruction <= imem_rdata;
                        p_count     <= fetch_pc;
                        inst_valid  <= 1'b1;
                    end else begin
                        inst_valid  <= 1'b0;
                    end
                end else if (load_entry) begin
                    // Output is stalled; requests stop while skid is occupied.
                    skid_instr <= imem_rdata;
                    skid_pc    <= fetch_pc;
                    skid_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural memory with adjustable latency, a
// program-order stream model for delivered instructions, directed and random phases.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] p_count;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instruction    (instruction),
        .p_count        (p_count),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;
    int lat      = 1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name, input int act, input int lim);
        n_checks++;
        $display("FAIL %s: got %0d, required <= %0d (t=%0t)", name, act, lim, $time);
    endtask

    // ---------------- memory model ----------------
    // Responds in the lat-th consecutive cycle a request is presented at one address.
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt  = 0;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        #2;
        if (imem_req) begin
            if (!mem_busy || imem_addr != mem_addr) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = 1;
            end else begin
                mem_cnt++;
            end
            if (mem_cnt >= lat) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_f(imem_addr);
                mem_busy    = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            mem_busy    = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    // exp_q holds the upcoming program-order addresses; redirect/reset restart it.
    logic [31:0] exp_q[$];

    task automatic refill(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    logic        prev_rstn = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_redirect = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_rvalid = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    int          stall = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            refill(RST_PC);
            stall = 0;
        end else begin
            if (prev_rstn && prev_valid && !prev_ready && !prev_redirect) begin
                chk("hold_valid", 32'(inst_valid), 32'd1);
                chk("hold_pc", p_count, prev_pc);
                chk("hold_instr", instruction, prev_instr);
            end
            if (prev_rstn && prev_req && !prev_rvalid && !prev_redirect) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_stable", imem_addr, prev_addr);
            end
            if (inst_valid && inst_ready) begin
                chk("sb_pc", p_count, exp_q[0]);
                chk("sb_instr", instruction, mem_f(exp_q[0]));
                exp_q.push_back(exp_q[$] + 32'd4);
                void'(exp_q.pop_front());
                n_xfer++;
                stall = 0;
            end else if (inst_ready) begin
                stall++;
            end
            if (redirect_valid) begin
                refill(redirect_pc & 32'hFFFF_FFFC);
                stall = 0;
            end
            if (stall > 16) begin
                fail_now("watchdog_stall", stall, 16);
                stall = 0;
            end
        end
        prev_rstn     = rst_n;
        prev_valid    = inst_valid;
        prev_ready    = inst_ready;
        prev_redirect = redirect_valid;
        prev_req      = imem_req;
        prev_rvalid   = imem_rvalid;
        prev_addr     = imem_addr;
        prev_pc       = p_count;
        prev_instr    = instruction;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge; returns #1 into the first cycle out of reset.
    task automatic do_reset(input string name);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk({name, "_req_in_reset"}, 32'(imem_req), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_first_valid(input string name, input logic [31:0] exp_pc);
        int k;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (inst_valid) break;
            tick();
        end
        chk({name, "_seen"}, 32'(inst_valid), 32'd1);
        chk({name, "_pc"}, p_count, exp_pc);
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] wrap_exp[4];
        int          k;
        int          xfer_start;
        logic        last_rd;

        // reset, latency 1, ready low for 5 cycles from the first valid beat
        tbl[0] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h104, 1'b1, 32'h100};
        tbl[2] = '{1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[3] = '{1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[4] = '{1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[5] = '{1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[6] = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[7] = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
        tbl[8] = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h108};
        tbl[9] = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h10C};

        rst_n = 1'b0;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        lat = 1;
        tick();
        do_reset("t1");
        for (int i = 0; i < 10; i++) begin
            inst_ready = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_pc", i), p_count, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_instr", i), instruction,
                tbl[i].exp_valid ? mem_f(tbl[i].exp_pc) : 32'h0);
            tick();
        end

        // redirect coinciding with the response for 0x104
        inst_ready = 1'b1;
        do_reset("t2");
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_3000;
        @(negedge clk);
        chk("t2_addr_at_redirect", imem_addr, 32'h104);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t2_valid_flushed", 32'(inst_valid), 32'd0);
        chk("t2_req", 32'(imem_req), 32'd1);
        chk("t2_addr_target", imem_addr, 32'h3000);
        tick();
        @(negedge clk);
        chk("t2_first_pc", p_count, 32'h3000);
        tick();

        // redirect while a latency-3 request to 0x10C is outstanding
        lat = 3;
        do_reset("t3");
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h10C) break;
            tick();
        end
        chk("t3_found_10c", 32'(imem_req && imem_addr == 32'h10C), 32'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2003;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_valid_flushed", 32'(inst_valid), 32'd0);
        chk("t3_drain_req", 32'(imem_req), 32'd1);
        chk("t3_drain_addr", imem_addr, 32'h10C);
        tick();
        @(negedge clk);
        chk("t3_next_addr", imem_addr, 32'h2000);
        chk("t3_next_req", 32'(imem_req), 32'd1);
        tick();
        wait_first_valid("t3_first", 32'h2000);

        // address wrap at the top of the space
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;
        k = 0;
        for (int c = 0; c < 30 && k < 4; c++) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                chk($sformatf("t4_wrap%0d", k), p_count, wrap_exp[k]);
                k++;
            end
            tick();
        end
        chk("t4_wrap_count", 32'(k), 32'd4);

        // reset mid-stream with the skid full
        inst_ready = 1'b0;
        repeat (4) tick();
        do_reset("t5a");
        inst_ready = 1'b1;
        @(negedge clk);
        chk("t5a_valid", 32'(inst_valid), 32'd0);
        chk("t5a_req", 32'(imem_req), 32'd1);
        chk("t5a_addr", imem_addr, RST_PC);
        wait_first_valid("t5a_first", RST_PC);

        // reset while a latency-3 request is outstanding
        lat = 3;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (imem_req && !imem_rvalid) break;
            tick();
        end
        tick();
        do_reset("t5b");
        @(negedge clk);
        chk("t5b_valid", 32'(inst_valid), 32'd0);
        chk("t5b_addr", imem_addr, RST_PC);
        wait_first_valid("t5b_first", RST_PC);

        // randomized traffic checked by the stream model
        xfer_start = n_xfer;
        last_rd = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) lat = $urandom_range(1, 4);
            rst_n = ($urandom_range(0, 399) != 0);
            if (rst_n && !last_rd && $urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ?
                              32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
            last_rd = redirect_valid;
            tick();
        end
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        repeat (3) tick();
        chk("rand_progress", 32'(n_xfer - xfer_start > 200), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
